// File: rtl/vga_rect_fill.sv
// Rectangle-fill engine: clips a solid rgb332 rectangle to the screen and writes it
// into the frame buffer as word-packed AXI4-Lite writes with byte strobes.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// SETUP | compute clipped bounds, first word address, empty check
// WRITE | AW and W offered together, each dropped after its own handshake
// RESP  | BREADY high, accumulate error, advance word/row
// DONE  | one-cycle done pulse, then back to IDLE
module vga_rect_fill #(
    parameter int PIXEL_WIDTH    = 640,
    parameter int PIXEL_HEIGHT   = 480,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cmd_valid,
    output logic                              cmd_ready,
    input  logic [$clog2(PIXEL_WIDTH)-1:0]    cmd_x,
    input  logic [$clog2(PIXEL_HEIGHT)-1:0]   cmd_y,
    input  logic [$clog2(PIXEL_WIDTH):0]      cmd_w,
    input  logic [$clog2(PIXEL_HEIGHT):0]     cmd_h,
    input  logic [7:0]                        cmd_color,
    output logic                              busy,
    output logic                              done,
    output logic                              err,
    output logic [AXI_ADDR_WIDTH-1:0]         axi_awaddr,
    output logic [2:0]                        axi_awprot,
    output logic                              axi_awvalid,
    input  logic                              axi_awready,
    output logic [AXI_DATA_WIDTH-1:0]         axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]       axi_wstrb,
    output logic                              axi_wvalid,
    input  logic                              axi_wready,
    input  logic [1:0]                        axi_bresp,
    input  logic                              axi_bvalid,
    output logic                              axi_bready,
    output logic [AXI_ADDR_WIDTH-1:0]         axi_araddr,
    output logic [2:0]                        axi_arprot,
    output logic                              axi_arvalid,
    output logic                              axi_rready
);
    localparam int XW    = $clog2(PIXEL_WIDTH);
    localparam int YW    = $clog2(PIXEL_HEIGHT);
    localparam int AW    = AXI_ADDR_WIDTH;
    localparam int BYTES = AXI_DATA_WIDTH / 8;
    localparam int LB    = $clog2(BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRITE,
        S_RESP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [XW-1:0] x0_q, x1_q, col_q, first_col_q, last_col_q;
    logic [YW-1:0] y0_q, y1_q, y_q;
    logic [XW:0]   w_q;
    logic [YW:0]   h_q;
    logic [7:0]    color_q;
    logic [AW-1:0] row_base_q;
    logic          aw_pend_q, w_pend_q, err_q;

    logic          accept;
    logic          last_word;
    logic          empty_d;
    logic [XW+1:0] x_end, x_clip;
    logic [YW+1:0] y_end, y_clip;
    logic [XW-1:0] x1_d;
    logic [YW-1:0] y1_d;
    logic [XW:0]   col_k;

    assign cmd_ready = (state_q == S_IDLE) && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign last_word = (col_q == last_col_q) && (y_q == y1_q);

    // Clipping uses two extra bits so x+w and y+h never wrap.
    always_comb begin
        x_end   = (XW+2)'(x0_q) + (XW+2)'(w_q);
        y_end   = (YW+2)'(y0_q) + (YW+2)'(h_q);
        x_clip  = (x_end > (XW+2)'(PIXEL_WIDTH))  ? (XW+2)'(PIXEL_WIDTH)  : x_end;
        y_clip  = (y_end > (YW+2)'(PIXEL_HEIGHT)) ? (YW+2)'(PIXEL_HEIGHT) : y_end;
        x1_d    = XW'(x_clip - (XW+2)'(1));
        y1_d    = YW'(y_clip - (YW+2)'(1));
        empty_d = (w_q == '0) || (h_q == '0) ||
                  ({1'b0, x0_q} >= (XW+1)'(PIXEL_WIDTH)) ||
                  ({1'b0, y0_q} >= (YW+1)'(PIXEL_HEIGHT));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_SETUP;
            S_SETUP: state_d = empty_d ? S_DONE : S_WRITE;
            S_WRITE: if (!aw_pend_q && !w_pend_q) state_d = S_RESP;
            S_RESP:  if (axi_bvalid) state_d = last_word ? S_DONE : S_WRITE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            x0_q        <= '0;
            y0_q        <= '0;
            w_q         <= '0;
            h_q         <= '0;
            color_q     <= '0;
            x1_q        <= '0;
            y1_q        <= '0;
            y_q         <= '0;
            col_q       <= '0;
            first_col_q <= '0;
            last_col_q  <= '0;
            row_base_q  <= '0;
            aw_pend_q   <= 1'b0;
            w_pend_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        x0_q    <= cmd_x;
                        y0_q    <= cmd_y;
                        w_q     <= cmd_w;
                        h_q     <= cmd_h;
                        color_q <= cmd_color;
                        err_q   <= 1'b0;
                    end
                end
                S_SETUP: begin
                    x1_q        <= x1_d;
                    y1_q        <= y1_d;
                    y_q         <= y0_q;
                    col_q       <= {x0_q[XW-1:LB], LB'(0)};
                    first_col_q <= {x0_q[XW-1:LB], LB'(0)};
                    last_col_q  <= {x1_d[XW-1:LB], LB'(0)};
                    // Single multiply per command; rows after this step by adding the width.
                    row_base_q  <= AW'(y0_q) * AW'(PIXEL_WIDTH);
                    if (!empty_d) begin
                        aw_pend_q <= 1'b1;
                        w_pend_q  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (aw_pend_q && axi_awready) aw_pend_q <= 1'b0;
                    if (w_pend_q && axi_wready)   w_pend_q  <= 1'b0;
                end
                S_RESP: begin
                    if (axi_bvalid) begin
                        err_q <= err_q | (axi_bresp != 2'b00);
                        if (!last_word) begin
                            aw_pend_q <= 1'b1;
                            w_pend_q  <= 1'b1;
                            if (col_q == last_col_q) begin
                                col_q      <= first_col_q;
                                y_q        <= y_q + YW'(1);
                                row_base_q <= row_base_q + AW'(PIXEL_WIDTH);
                            end else begin
                                col_q <= col_q + XW'(BYTES);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        axi_wstrb = '0;
        col_k     = '0;
        for (int k = 0; k < BYTES; k++) begin
            col_k        = (XW+1)'(col_q) + (XW+1)'(k);
            axi_wstrb[k] = (col_k >= {1'b0, x0_q}) && (col_k <= {1'b0, x1_q});
        end
    end

    assign axi_awaddr  = row_base_q + AW'(col_q);
    assign axi_awprot  = 3'b000;
    assign axi_awvalid = aw_pend_q;
    assign axi_wdata   = {BYTES{color_q}};
    assign axi_wvalid  = w_pend_q;
    assign axi_bready  = (state_q == S_RESP);

    assign axi_araddr  = '0;
    assign axi_arprot  = 3'b000;
    assign axi_arvalid = 1'b0;
    assign axi_rready  = 1'b0;

    assign busy = (state_q == S_SETUP) || (state_q == S_WRITE) || (state_q == S_RESP);
    assign done = (state_q == S_DONE);
    assign err  = err_q;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill with a behavioural AXI4-Lite write subordinate
// that supports per-channel ready delays and an injected SLVERR.
module tb_vga_rect_fill;
    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [9:0]  cmd_x;
    logic [8:0]  cmd_y;
    logic [10:0] cmd_w;
    logic [9:0]  cmd_h;
    logic [7:0]  cmd_color;
    logic        busy, done, err;
    logic [18:0] awaddr, araddr;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp;

    always #5 clk = ~clk;

    vga_rect_fill dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
        .busy(busy), .done(done), .err(err),
        .axi_awaddr(awaddr), .axi_awprot(awprot), .axi_awvalid(awvalid), .axi_awready(awready),
        .axi_wdata(wdata), .axi_wstrb(wstrb), .axi_wvalid(wvalid), .axi_wready(wready),
        .axi_bresp(bresp), .axi_bvalid(bvalid), .axi_bready(bready),
        .axi_araddr(araddr), .axi_arprot(arprot), .axi_arvalid(arvalid), .axi_rready(rready)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // subordinate model state
    int          aw_delay = 0, w_delay = 0, err_word = -1;
    int          aw_wait = 0, w_wait = 0, pair_cnt = 0;
    int          aw_vld_cycles = 0, done_cnt = 0, stab_viol = 0, drop_viol = 0;
    bit          aw_got, w_got, b_arm, b_arm_err, b_take;
    bit          aw_prev_pend, w_prev_pend, aw_prev_hs, w_prev_hs;
    logic [18:0] aw_prev_addr;
    logic [31:0] w_prev_data;
    logic [3:0]  w_prev_strb;
    logic [18:0] aw_log[$];
    logic [31:0] wd_log[$];
    logic [3:0]  ws_log[$];

    initial begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    end

    always @(negedge clk) begin
        if (rst) begin
            awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
            aw_wait = 0; w_wait = 0; aw_got = 0; w_got = 0;
            b_arm = 0; b_take = 0;
            aw_prev_pend = 0; w_prev_pend = 0; aw_prev_hs = 0; w_prev_hs = 0;
        end else begin
            if (done)    done_cnt++;
            if (awvalid) aw_vld_cycles++;
            if (aw_prev_pend && (!awvalid || awaddr !== aw_prev_addr)) stab_viol++;
            if (w_prev_pend && (!wvalid || wdata !== w_prev_data || wstrb !== w_prev_strb)) stab_viol++;
            if (aw_prev_hs && awvalid) drop_viol++;
            if (w_prev_hs && wvalid)   drop_viol++;

            if (b_take) begin bvalid = 1'b0; b_take = 0; end
            if (b_arm)  begin bvalid = 1'b1; bresp = b_arm_err ? 2'b10 : 2'b00; b_arm = 0; end
            if (bvalid && bready) b_take = 1;

            aw_prev_hs = 0; aw_prev_pend = 0;
            if (awvalid && !aw_got) begin
                if (aw_wait >= aw_delay) begin
                    awready = 1'b1; aw_wait = 0; aw_got = 1; aw_prev_hs = 1;
                    aw_log.push_back(awaddr);
                end else begin
                    awready = 1'b0; aw_wait++; aw_prev_pend = 1; aw_prev_addr = awaddr;
                end
            end else awready = 1'b0;

            w_prev_hs = 0; w_prev_pend = 0;
            if (wvalid && !w_got) begin
                if (w_wait >= w_delay) begin
                    wready = 1'b1; w_wait = 0; w_got = 1; w_prev_hs = 1;
                    wd_log.push_back(wdata); ws_log.push_back(wstrb);
                end else begin
                    wready = 1'b0; w_wait++; w_prev_pend = 1;
                    w_prev_data = wdata; w_prev_strb = wstrb;
                end
            end else wready = 1'b0;

            if (aw_got && w_got) begin
                aw_got = 0; w_got = 0; b_arm = 1;
                b_arm_err = (pair_cnt == err_word);
                pair_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns latency counted so that the cycle after the accept cycle is 1.
    task automatic run_cmd(input int x, input int y, input int w, input int h, input int c,
                           output int lat, output logic busy1, output logic err1);
        int n = 0;
        while (!cmd_ready && n < 200) begin tick(); n++; end
        cmd_valid = 1'b1;
        cmd_x = 10'(x); cmd_y = 9'(y); cmd_w = 11'(w); cmd_h = 10'(h); cmd_color = 8'(c);
        tick();
        cmd_valid = 1'b0;
        lat = 1; busy1 = busy; err1 = err;
        while (!done && lat < 500) begin tick(); lat++; end
        if (!done) lat = -1;
    endtask

    int          lat, base, d0, n;
    logic        b1, e1;
    logic [18:0] exp_addr[4];

    initial begin
        rst = 1'b1; cmd_valid = 1'b0;
        cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
        tick(); tick();
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_awvalid", awvalid, 0);
        rst = 1'b0;
        tick();
        check("post_rst_cmd_ready", cmd_ready, 1);
        check("post_rst_outputs", {busy, done, err, awvalid, wvalid, bready}, 0);

        // partial words
        base = aw_log.size();
        run_cmd(2, 1, 5, 1, 8'hE0, lat, b1, e1);
        check("part_busy_n1", b1, 1);
        check("part_latency", lat, 8);
        check("part_count", aw_log.size() - base, 2);
        check("part_addr0", aw_log[base], 19'h280);
        check("part_strb0", ws_log[base], 4'b1100);
        check("part_data0", wd_log[base], 32'hE0E0E0E0);
        check("part_addr1", aw_log[base+1], 19'h284);
        check("part_strb1", ws_log[base+1], 4'b0111);
        check("part_data1", wd_log[base+1], 32'hE0E0E0E0);
        check("part_err", err, 0);

        // clipping at the bottom-right corner
        base = aw_log.size();
        run_cmd(636, 479, 10, 5, 8'h1C, lat, b1, e1);
        check("clip_latency", lat, 5);
        check("clip_count", aw_log.size() - base, 1);
        check("clip_addr", aw_log[base], 307196);
        check("clip_strb", ws_log[base], 4'b1111);
        check("clip_data", wd_log[base], 32'h1C1C1C1C);
        check("clip_err", err, 0);

        // empty rectangles
        n = aw_vld_cycles;
        run_cmd(10, 10, 0, 3, 8'hFF, lat, b1, e1);
        check("empty_w0_latency", lat, 2);
        tick();
        check("empty_ready_after", cmd_ready, 1);
        run_cmd(700, 10, 4, 1, 8'hFF, lat, b1, e1);
        check("empty_xoff_latency", lat, 2);
        check("empty_no_awvalid", aw_vld_cycles - n, 0);

        // backpressure
        exp_addr = '{0, 4, 640, 644};
        aw_delay = 5; w_delay = 2;
        base = aw_log.size(); d0 = stab_viol; n = drop_viol;
        run_cmd(0, 0, 8, 2, 8'h55, lat, b1, e1);
        check("bp_latency", lat, 34);
        check("bp_count", aw_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("bp_addr%0d", i), aw_log[base+i], exp_addr[i]);
            check($sformatf("bp_strb%0d", i), ws_log[base+i], 4'b1111);
        end
        check("bp_stable", stab_viol - d0, 0);
        check("bp_drop", drop_viol - n, 0);
        aw_delay = 0; w_delay = 0;

        // SLVERR on the second write
        base = aw_log.size();
        err_word = pair_cnt + 1;
        run_cmd(0, 0, 8, 2, 8'h55, lat, b1, e1);
        check("err_latency", lat, 14);
        check("err_count", aw_log.size() - base, 4);
        check("err_at_done", err, 1);
        err_word = -1;
        tick(); tick();
        check("err_holds", err, 1);
        run_cmd(2, 1, 5, 1, 8'hE0, lat, b1, e1);
        check("err_cleared_n1", e1, 0);
        check("err_clean_done", err, 0);

        // reset during the third write of a 2x2-word rectangle
        tick();
        base = aw_log.size();
        cmd_valid = 1'b1; cmd_x = 10'd0; cmd_y = 9'd0; cmd_w = 11'd8; cmd_h = 10'd2; cmd_color = 8'h33;
        tick();
        cmd_valid = 1'b0;
        n = 0;
        while (!(awvalid && aw_log.size() == base + 2) && n < 100) begin tick(); n++; end
        check("rst_mid_reached", n < 100, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        d0 = done_cnt;
        check("rst_mid_awvalid", awvalid, 0);
        check("rst_mid_wvalid", wvalid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_cmd_ready", cmd_ready, 1);
        for (int i = 0; i < 10; i++) tick();
        check("rst_mid_no_done", done_cnt - d0, 0);
        base = aw_log.size();
        run_cmd(2, 1, 5, 1, 8'hE0, lat, b1, e1);
        check("after_rst_latency", lat, 8);
        check("after_rst_count", aw_log.size() - base, 2);
        check("after_rst_addr0", aw_log[base], 19'h280);
        check("after_rst_strb1", ws_log[base+1], 4'b0111);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
